// File: rtl/cnt_empty_pkg.sv
// Shared FIFO pointer helpers and default geometry, used by both read and write sides.
// Latency: n/a (pure functions and constants).
// Backpressure: n/a.
package cnt_empty_pkg;

  // Default pointer width including the wrap bit (depth = 2**(PTR_W_DEF-1))
  localparam int PTR_W_DEF       = 5;
  // Default synchronizer depth for pointers crossing clock domains
  localparam int SYNC_STAGES_DEF = 2;
  // Default almost-empty threshold in entries
  localparam int AE_THRESH_DEF   = 2;
  // Widest pointer the conversion helpers handle; callers zero-extend and truncate
  localparam int PTR_MAX_W       = 32;

  // Binary to reflected Gray code
  function automatic logic [PTR_MAX_W-1:0] bin2gray(input logic [PTR_MAX_W-1:0] b);
    return b ^ (b >> 1);
  endfunction

  // Reflected Gray code to binary: each bit is the XOR of all Gray bits at or above it.
  // Zero-extended inputs convert correctly because leading zeros do not disturb the prefix XOR.
  function automatic logic [PTR_MAX_W-1:0] gray2bin(input logic [PTR_MAX_W-1:0] g);
    logic [PTR_MAX_W-1:0] b;
    b[PTR_MAX_W-1] = g[PTR_MAX_W-1];
    for (int i = PTR_MAX_W - 2; i >= 0; i--) begin
      b[i] = b[i+1] ^ g[i];
    end
    return b;
  endfunction

endpackage

// File: rtl/cnt_empty_sync_gray.sv
// Multi-flop synchronizer for a Gray-coded pointer arriving from another clock domain.
// Latency: SYNC_STAGES clk edges from d to q.
// Backpressure: none; samples every cycle.
module sync_gray #(
  parameter int WIDTH       = 5,
  parameter int SYNC_STAGES = 2   // must be >= 2 for metastability settling
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] d,
  output logic [WIDTH-1:0] q
);

  logic [WIDTH-1:0] sync_d [SYNC_STAGES];
  logic [WIDTH-1:0] sync_q [SYNC_STAGES];

  // Pure shift wiring: no logic between stages so only single Gray bit changes propagate
  always_comb begin
    sync_d[0] = d;
    for (int i = 1; i < SYNC_STAGES; i++) begin
      sync_d[i] = sync_q[i-1];
    end
  end

  // Synchronizer chain; cleared only by reset, never by a functional clear
  always_ff @(posedge clk) begin
    if (!rst) begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= '0;
      end
    end else begin
      for (int i = 0; i < SYNC_STAGES; i++) begin
        sync_q[i] <= sync_d[i];
      end
    end
  end

  assign q = sync_q[SYNC_STAGES-1];

endmodule

// File: rtl/cnt_empty.sv
// Read-side pointer/empty logic of an async FIFO: read pointer, Gray pointer, empty/almost-empty, level.
// Latency: read advances pointer next edge; a write is visible SYNC_STAGES+1 edges after wr_gray_async changes.
// Backpressure: reads (en) are dropped while empty=1; clr and reset override reads.
module cnt_empty
  import cnt_empty_pkg::*;
#(
  parameter int WIDTH       = PTR_W_DEF,
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int AE_THRESH   = AE_THRESH_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             clr,
  input  logic             en,
  input  logic [WIDTH-1:0] wr_gray_async,
  output logic [WIDTH-1:0] rd_bin,
  output logic [WIDTH-1:0] rd_gray,
  output logic             empty,
  output logic             almost_empty,
  output logic [WIDTH-1:0] rd_level
);

  localparam logic [WIDTH-1:0] AE_LIM = WIDTH'(AE_THRESH);

  logic [WIDTH-1:0] wr_gray_sync;
  logic [WIDTH-1:0] wr_bin_sync;
  logic             rd_ok;

  logic [WIDTH-1:0] rd_bin_d,   rd_bin_q;
  logic [WIDTH-1:0] rd_gray_d,  rd_gray_q;
  logic [WIDTH-1:0] rd_level_d, rd_level_q;
  logic             empty_d,    empty_q;
  logic             almost_empty_d, almost_empty_q;

  sync_gray #(
    .WIDTH       (WIDTH),
    .SYNC_STAGES (SYNC_STAGES)
  ) u_sync_gray (
    .clk (clk),
    .rst (rst),
    .d   (wr_gray_async),
    .q   (wr_gray_sync)
  );

  // Next-state pointer and flags; flags derive from the next pointer so they track the read just taken
  always_comb begin
    rd_ok    = en && !empty_q && !clr;
    rd_bin_d = rd_bin_q;
    if (clr) begin
      rd_bin_d = '0;
    end else if (rd_ok) begin
      rd_bin_d = rd_bin_q + WIDTH'(1);
    end
    rd_gray_d      = WIDTH'(bin2gray(PTR_MAX_W'(rd_bin_d)));
    wr_bin_sync    = WIDTH'(gray2bin(PTR_MAX_W'(wr_gray_sync)));
    rd_level_d     = wr_bin_sync - rd_bin_d;
    empty_d        = (rd_gray_d == wr_gray_sync);
    almost_empty_d = empty_d || (rd_level_d <= AE_LIM);
    if (clr) begin
      rd_level_d     = '0;
      empty_d        = 1'b1;
      almost_empty_d = 1'b1;
    end
  end

  // Register pointer and flags; reset beats clr and en
  always_ff @(posedge clk) begin
    if (!rst) begin
      rd_bin_q       <= '0;
      rd_gray_q      <= '0;
      rd_level_q     <= '0;
      empty_q        <= 1'b1;
      almost_empty_q <= 1'b1;
    end else begin
      rd_bin_q       <= rd_bin_d;
      rd_gray_q      <= rd_gray_d;
      rd_level_q     <= rd_level_d;
      empty_q        <= empty_d;
      almost_empty_q <= almost_empty_d;
    end
  end

  assign rd_bin       = rd_bin_q;
  assign rd_gray      = rd_gray_q;
  assign rd_level     = rd_level_q;
  assign empty        = empty_q;
  assign almost_empty = almost_empty_q;

endmodule

// File: tb/tb_cnt_empty.sv
// Self-checking bench for cnt_empty: directed steps plus a randomized stream vs an occupancy model.
// Latency: n/a.
// Backpressure: n/a.
module tb_cnt_empty;

  localparam int W  = 5;
  localparam int S  = 2;
  localparam int AE = 2;
  localparam int M  = 32;   // pointer modulus 2**W

  logic         clk = 1'b0;
  logic         rst = 1'b0;
  logic         clr = 1'b0;
  logic         en  = 1'b0;
  logic [W-1:0] wr_gray_async = '0;
  logic [W-1:0] rd_bin;
  logic [W-1:0] rd_gray;
  logic         empty;
  logic         almost_empty;
  logic [W-1:0] rd_level;

  cnt_empty #(
    .WIDTH       (W),
    .SYNC_STAGES (S),
    .AE_THRESH   (AE)
  ) dut (
    .clk           (clk),
    .rst           (rst),
    .clr           (clr),
    .en            (en),
    .wr_gray_async (wr_gray_async),
    .rd_bin        (rd_bin),
    .rd_gray       (rd_gray),
    .empty         (empty),
    .almost_empty  (almost_empty),
    .rd_level      (rd_level)
  );

  always #5 clk = ~clk;

  int tests = 0;
  int fails = 0;

  // Reference model: write pointer as a plain binary count, read count, and an input history
  int wr       = 0;
  int n        = 0;
  int last_rst = 0;
  int in_hist [0:8191];
  int m_rd     = 0;
  int m_level  = 0;
  bit m_empty  = 1'b1;
  bit m_ae     = 1'b1;
  int wraps    = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, obs, exp);
    end
  endtask

  // One clock: drive inputs, advance the model, compare every output #1 after the edge
  task automatic step(input bit r, input bit c, input bit e);
    int ws;
    logic [W-1:0] prev_rd;
    rst = r;
    clr = c;
    en  = e;
    wr_gray_async = W'(wr ^ (wr >> 1));
    prev_rd = rd_bin;
    @(posedge clk);
    n++;
    in_hist[n] = wr;
    if (!r) begin
      last_rst = n;
      m_rd = 0; m_level = 0; m_empty = 1'b1; m_ae = 1'b1;
    end else begin
      // Flags at this edge see the write pointer that has crossed S flops before this edge
      ws = (n - S > last_rst) ? in_hist[n - S] : 0;
      if (c) begin
        m_rd = 0; m_level = 0; m_empty = 1'b1; m_ae = 1'b1;
      end else begin
        if (e && !m_empty) m_rd = (m_rd + 1) % M;
        m_level = (ws - m_rd + M) % M;
        m_empty = (m_level == 0);
        m_ae    = (m_level <= AE);
      end
    end
    #1;
    if (prev_rd == W'(M - 1) && rd_bin == '0) wraps++;
    chk("rd_bin",       rd_bin,       m_rd);
    chk("rd_gray",      rd_gray,      m_rd ^ (m_rd >> 1));
    chk("empty",        empty,        m_empty);
    chk("almost_empty", almost_empty, m_ae);
    chk("rd_level",     rd_level,     m_level);
  endtask

  initial begin
    // Reset held two cycles, then released
    step(0, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    chk("rst_rd_bin", rd_bin, 0);
    chk("rst_rd_gray", rd_gray, 0);
    chk("rst_empty", empty, 1);
    chk("rst_ae", almost_empty, 1);
    chk("rst_level", rd_level, 0);

    // Underflow: reads while empty are ignored
    repeat (5) step(1, 0, 1);
    chk("uflow_rd_bin", rd_bin, 0);
    chk("uflow_empty", empty, 1);

    // Single write visible on the 3rd edge, then one read empties again
    wr = 1;
    step(1, 0, 0);
    chk("vis_e1_empty", empty, 1);
    step(1, 0, 0);
    chk("vis_e2_empty", empty, 1);
    step(1, 0, 0);
    chk("vis_e3_empty", empty, 0);
    chk("vis_e3_level", rd_level, 1);
    step(1, 0, 1);
    chk("rd1_rd_bin", rd_bin, 1);
    chk("rd1_empty", empty, 1);

    // Full FIFO: write pointer 16 against read pointer 0
    wr = 0;
    step(0, 0, 0);
    step(0, 0, 0);
    step(1, 0, 0);
    wr = 16;
    repeat (3) step(1, 0, 0);
    chk("full_level", rd_level, 16);
    chk("full_empty", empty, 0);
    chk("full_ae", almost_empty, 0);
    repeat (16) step(1, 0, 1);
    chk("drain_rd_bin", rd_bin, 16);
    chk("drain_rd_gray", rd_gray, 5'b11000);
    chk("drain_empty", empty, 1);

    // Randomized stream with concurrent writes and reads, crossing the pointer wrap
    for (int i = 0; i < 160; i++) begin
      if (((wr - m_rd + M) % M) < 16 && $urandom_range(0, 1) == 1) wr = (wr + 1) % M;
      step(1, 0, $urandom_range(0, 3) != 0);
    end
    chk("wrap_seen", wraps != 0, 1);

    // Clear with a read pending at rd_bin=7
    wr = 0;
    step(0, 0, 0);
    step(1, 0, 0);
    wr = 9;
    repeat (3) step(1, 0, 0);
    repeat (7) step(1, 0, 1);
    chk("pre_clr_rd_bin", rd_bin, 7);
    step(1, 1, 1);
    chk("clr_rd_bin", rd_bin, 0);
    chk("clr_empty", empty, 1);
    chk("clr_level", rd_level, 0);
    chk("clr_ae", almost_empty, 1);
    step(1, 0, 0);
    chk("post_clr_level", rd_level, 9);

    // Mid-stream reset beats clr and en
    repeat (3) step(1, 0, 1);
    step(0, 1, 1);
    chk("mrst_rd_bin", rd_bin, 0);
    chk("mrst_empty", empty, 1);
    chk("mrst_ae", almost_empty, 1);
    wr = 0;
    step(0, 0, 1);
    step(1, 0, 1);
    chk("mrst_rel_rd_bin", rd_bin, 0);
    wr = 2;
    repeat (6) step(1, 0, 1);
    chk("mrst_reads_rd_bin", rd_bin, 2);
    chk("mrst_reads_empty", empty, 1);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
